// File: rtl/qam_clk_carrier_mod.sv
// QAM transmitter back end: master-clock dividers, quadrature DDS carrier
// and I/Q mixer producing the modulated output.
module qam_clk_carrier_mod #(
    parameter int BIT_DIV_BASE = 9216,
    parameter int SPS          = 16,
    parameter int ANALOG_DIV   = 16,
    parameter int PHASE_K      = 6214,
    parameter int MOD_SHIFT    = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mod_type,
    input  logic [1:0]         baud_rate,
    input  logic [15:0]        carrier_freq_set,
    input  logic signed [67:0] baseband_i,
    input  logic signed [67:0] baseband_q,
    output logic               clk_bitstream,
    output logic               clk_symbol,
    output logic               clk_filter_sample,
    output logic               clk_analog_sample,
    output logic signed [31:0] carrier_i,
    output logic signed [31:0] carrier_q,
    output logic signed [76:0] mod_iq
);

    localparam logic [15:0] BIT_BASE = 16'(BIT_DIV_BASE);
    localparam int          SPS_SH   = $clog2(SPS);
    localparam int          AW       = $clog2(ANALOG_DIV);
    localparam logic [AW-1:0] ANA_LAST = AW'(ANALOG_DIV - 1);
    localparam logic [AW-1:0] ANA_HALF = AW'(ANALOG_DIV / 2);
    localparam logic [31:0] K_PH     = 32'(PHASE_K);
    localparam logic [63:0] PI_Q60   = 64'h3243_F6A8_885A_308D;

    // Quarter-wave sine table, built at elaboration with a Q60 Taylor series
    function automatic logic [65*32-1:0] build_qw();
        logic [65*32-1:0] r;
        logic [127:0]     x;
        logic [127:0]     x2;
        logic [127:0]     term;
        logic [127:0]     s;
        logic [127:0]     v;
        r = '0;
        for (int k = 0; k < 65; k++) begin
            x    = (128'(PI_Q60) * 128'(k)) >> 7;
            x2   = (x * x) >> 60;
            term = x;
            s    = x;
            for (int n = 1; n < 12; n++) begin
                term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
                if (n % 2 == 1) s = s - term;
                else            s = s + term;
            end
            v = (s * 128'(32'h3FFF_FFFF) + (128'd1 << 59)) >> 60;
            r[k*32 +: 32] = v[31:0];
        end
        return r;
    endfunction

    localparam logic [65*32-1:0] QW = build_qw();

    function automatic logic [31:0] sin_lut(input logic [7:0] p);
        logic [6:0]  idx;
        logic [31:0] mag;
        idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
        mag = QW[{idx, 5'd0} +: 32];
        return p[7] ? (32'd0 - mag) : mag;
    endfunction

    logic [15:0]       n_bit;
    logic [15:0]       n_sym;
    logic [2:0][15:0]  n_div;
    logic [2:0][15:0]  div_cnt;
    logic [2:0][15:0]  div_nxt;
    logic [2:0]        div_clk;
    logic              mod_q;
    logic [1:0]        baud_q;
    logic              cfg_vld;
    logic              cfg_chg;

    always_comb begin
        n_bit    = BIT_BASE >> baud_rate;
        n_sym    = mod_type ? (n_bit << 2) : (n_bit << 1);
        n_div[0] = n_bit;
        n_div[1] = n_sym;
        n_div[2] = n_sym >> SPS_SH;
        div_nxt  = '0;
        for (int i = 0; i < 3; i++) begin
            div_nxt[i] = (div_cnt[i] == n_div[i] - 16'd1) ? 16'd0
                                                          : div_cnt[i] + 16'd1;
        end
    end

    // The first cycle out of reset only captures the configuration
    assign cfg_chg = cfg_vld &&
                     ((mod_type != mod_q) || (baud_rate != baud_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            div_clk <= '0;
            cfg_vld <= 1'b0;
            mod_q   <= 1'b0;
            baud_q  <= 2'd0;
        end else begin
            cfg_vld <= 1'b1;
            mod_q   <= mod_type;
            baud_q  <= baud_rate;
            if (cfg_chg) begin
                div_cnt <= '0;
                div_clk <= '0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    div_cnt[i] <= div_nxt[i];
                    div_clk[i] <= (div_nxt[i] >= (n_div[i] >> 1));
                end
            end
        end
    end

    assign clk_bitstream     = div_clk[0];
    assign clk_symbol        = div_clk[1];
    assign clk_filter_sample = div_clk[2];

    logic [AW-1:0] ana_cnt;
    logic [AW-1:0] ana_nxt;
    logic          sample_evt;
    logic [31:0]   phase;
    logic [31:0]   phase_inc;

    assign sample_evt = (ana_cnt == ANA_LAST);
    assign ana_nxt    = sample_evt ? '0 : ana_cnt + 1'b1;
    assign phase_inc  = 32'(carrier_freq_set) * K_PH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ana_cnt           <= '0;
            clk_analog_sample <= 1'b0;
            phase             <= '0;
            carrier_i         <= '0;
            carrier_q         <= '0;
        end else begin
            ana_cnt           <= ana_nxt;
            clk_analog_sample <= (ana_nxt >= ANA_HALF);
            if (sample_evt) begin
                carrier_q <= sin_lut(phase[31:24]);
                carrier_i <= sin_lut(phase[31:24] + 8'd64);
                phase     <= phase + phase_inc;
            end
        end
    end

    logic signed [99:0]  bi_x;
    logic signed [99:0]  bq_x;
    logic signed [99:0]  ci_x;
    logic signed [99:0]  cq_x;
    logic signed [99:0]  prod_i;
    logic signed [99:0]  prod_q;
    logic        [100:0] mix;

    assign bi_x   = {{32{baseband_i[67]}}, baseband_i};
    assign bq_x   = {{32{baseband_q[67]}}, baseband_q};
    assign ci_x   = {{68{carrier_i[31]}}, carrier_i};
    assign cq_x   = {{68{carrier_q[31]}}, carrier_q};
    assign prod_i = bi_x * ci_x;
    assign prod_q = bq_x * cq_x;
    assign mix    = {prod_i[99], prod_i} - {prod_q[99], prod_q};
    assign mod_iq = mix[MOD_SHIFT +: 77];

endmodule

// File: tb/tb_qam_clk_carrier_mod.sv
// Bench for qam_clk_carrier_mod: divider timing table, DDS/mixer scenarios
// and a randomized run against a cycle-level reference model.
module tb_qam_clk_carrier_mod;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               mod_type = 1'b1;
    logic [1:0]         baud_rate = 2'd0;
    logic [15:0]        carrier_freq_set = 16'd0;
    logic signed [67:0] baseband_i = '0;
    logic signed [67:0] baseband_q = '0;
    logic               clk_bitstream;
    logic               clk_symbol;
    logic               clk_filter_sample;
    logic               clk_analog_sample;
    logic signed [31:0] carrier_i;
    logic signed [31:0] carrier_q;
    logic signed [76:0] mod_iq;

    always #5 clk = ~clk;

    qam_clk_carrier_mod dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mod_type          (mod_type),
        .baud_rate         (baud_rate),
        .carrier_freq_set  (carrier_freq_set),
        .baseband_i        (baseband_i),
        .baseband_q        (baseband_q),
        .clk_bitstream     (clk_bitstream),
        .clk_symbol        (clk_symbol),
        .clk_filter_sample (clk_filter_sample),
        .clk_analog_sample (clk_analog_sample),
        .carrier_i         (carrier_i),
        .carrier_q         (carrier_q),
        .mod_iq            (mod_iq)
    );

    localparam longint AMP = 64'sd1073741823;
    localparam logic signed [76:0] MIQ = 77'sd70368744112128;
    localparam logic signed [67:0] BB40 = 68'sd1099511627776;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic chk_ok(input string name, input bit ok,
                          input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic longint sin_ref(input int p);
        real r;
        r = 1073741823.0 * $sin(2.0 * 3.14159265358979323846 * real'(p) / 256.0);
        if (r >= 0.0) return longint'($floor(r + 0.5));
        return -longint'($floor(-r + 0.5));
    endfunction

    // Reference model: elapsed cycles since divider restart / reset
    int                 m_t_cfg;
    int                 m_t_ana;
    bit                 m_have;
    logic               m_mod;
    logic [1:0]         m_baud;
    logic [31:0]        m_phase;
    logic signed [31:0] m_ci;
    logic signed [31:0] m_cq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t_cfg <= 0;
            m_t_ana <= 0;
            m_have  <= 1'b0;
            m_mod   <= 1'b0;
            m_baud  <= 2'd0;
            m_phase <= '0;
            m_ci    <= '0;
            m_cq    <= '0;
        end else begin
            if (m_have && (mod_type !== m_mod || baud_rate !== m_baud))
                m_t_cfg <= 0;
            else
                m_t_cfg <= m_t_cfg + 1;
            m_have  <= 1'b1;
            m_mod   <= mod_type;
            m_baud  <= baud_rate;
            m_t_ana <= m_t_ana + 1;
            if ((m_t_ana + 1) % 16 == 0) begin
                m_cq    <= 32'(sin_ref(int'(m_phase[31:24])));
                m_ci    <= 32'(sin_ref(int'(8'(m_phase[31:24] + 8'd64))));
                m_phase <= m_phase + 32'(carrier_freq_set) * 32'd6214;
            end
        end
    end

    task automatic check_all();
        int nb, ns, nf;
        logic [100:0] ea, eb, es;
        logic signed [76:0] e_iq;
        nb = 9216 >> m_baud;
        ns = nb * (m_mod ? 4 : 2);
        nf = ns / 16;
        chk("clk_bitstream", clk_bitstream, (m_t_cfg % nb) >= nb / 2);
        chk("clk_symbol", clk_symbol, (m_t_cfg % ns) >= ns / 2);
        chk("clk_filter_sample", clk_filter_sample, (m_t_cfg % nf) >= nf / 2);
        chk("clk_analog_sample", clk_analog_sample, (m_t_ana % 16) >= 8);
        chk("carrier_i", carrier_i, m_ci);
        chk("carrier_q", carrier_q, m_cq);
        ea = {{33{baseband_i[67]}}, baseband_i} * {{69{m_ci[31]}}, m_ci};
        eb = {{33{baseband_q[67]}}, baseband_q} * {{69{m_cq[31]}}, m_cq};
        es = ea - eb;
        e_iq = es[100:24];
        chk("mod_iq", mod_iq, e_iq);
    endtask

    // Edge tracker: 0 bit, 1 symbol, 2 filter, 3 analog
    int         edge_n;
    logic [3:0] prev_clk;
    int         rise1 [4];
    int         rise2 [4];
    int         fall1 [4];

    function automatic logic [3:0] cur_clk();
        return {clk_analog_sample, clk_filter_sample, clk_symbol, clk_bitstream};
    endfunction

    task automatic mark();
        edge_n   = 0;
        prev_clk = cur_clk();
        for (int i = 0; i < 4; i++) begin
            rise1[i] = -1;
            rise2[i] = -1;
            fall1[i] = -1;
        end
    endtask

    task automatic cyc();
        logic [3:0] c;
        @(posedge clk);
        #2;
        check_all();
        edge_n++;
        c = cur_clk();
        for (int i = 0; i < 4; i++) begin
            if (c[i] && !prev_clk[i]) begin
                if (rise1[i] < 0) rise1[i] = edge_n;
                else if (rise2[i] < 0) rise2[i] = edge_n;
            end
            if (!c[i] && prev_clk[i] && rise1[i] >= 0 && fall1[i] < 0)
                fall1[i] = edge_n;
        end
        prev_clk = c;
    endtask

    typedef struct {
        logic       mt;
        logic [1:0] br;
        int         bit_rise;
        int         bit_fall;
        int         sym_rise;
        int         filt_rise;
        int         filt_rise2;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint prevq;
        int     last_x;
        int     n_sp;
        real    ci_r, cq_r, err;

        tbl[0] = '{1'b1, 2'd1, 2305, 4609, 9217, 577, 1729};
        tbl[1] = '{1'b1, 2'd2, 1153, 2305, 4609, 289, 865};
        tbl[2] = '{1'b1, 2'd3, 577, 1153, 2305, 145, 433};
        tbl[3] = '{1'b0, 2'd1, 2305, 4609, 4609, 289, 865};
        tbl[4] = '{1'b0, 2'd2, 1153, 2305, 2305, 145, 433};
        tbl[5] = '{1'b0, 2'd3, 577, 1153, 1153, 73, 217};

        // Reset state, 16-QAM at 1200 bit/s, zero carrier frequency
        baseband_i = BB40;
        repeat (3) cyc();
        chk("reset_bit", clk_bitstream, 0);
        chk("reset_carrier_i", carrier_i, 0);
        chk("reset_mod_iq", mod_iq, 0);
        #3 rst_n = 1'b1;
        mark();
        repeat (16) cyc();
        chk("first_cos", carrier_i, 32'sd1073741823);
        chk("first_sin", carrier_q, 0);
        chk("miq_pos", mod_iq, MIQ);
        baseband_i = -BB40;
        #1;
        chk("miq_neg", mod_iq, -MIQ);
        while (edge_n < 18440) cyc();
        chk("s1_bit_rise", rise1[0], 4608);
        chk("s1_bit_fall", fall1[0], 9216);
        chk("s1_bit_rise2", rise2[0], 13824);
        chk("s1_filt_rise", rise1[2], 1152);
        chk("s1_filt_rise2", rise2[2], 3456);
        chk("s1_sym_rise", rise1[1], 18432);
        chk("s1_ana_rise", rise1[3], 8);
        chk("s1_ana_fall", fall1[3], 16);
        chk("s1_ana_rise2", rise2[3], 24);
        chk("freq0_cos", carrier_i, 32'sd1073741823);
        chk("freq0_sin", carrier_q, 0);

        // Asynchronous reset mid-run, then the same start-up sequence
        repeat ($urandom_range(1, 50)) cyc();
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_bit", clk_bitstream, 0);
        chk("midrst_sym", clk_symbol, 0);
        chk("midrst_filt", clk_filter_sample, 0);
        chk("midrst_ana", clk_analog_sample, 0);
        chk("midrst_ci", carrier_i, 0);
        chk("midrst_cq", carrier_q, 0);
        chk("midrst_miq", mod_iq, 0);
        repeat (4) cyc();
        #1 rst_n = 1'b1;
        mark();
        while (edge_n < 4700) cyc();
        chk("s6_bit_rise", rise1[0], 4608);
        chk("s6_filt_rise", rise1[2], 1152);
        chk("s6_filt_rise2", rise2[2], 3456);
        chk("s6_ana_rise", rise1[3], 8);
        chk("s6_cos", carrier_i, 32'sd1073741823);

        // Configuration switches mid-run
        foreach (tbl[e]) begin
            mod_type  = tbl[e].mt;
            baud_rate = tbl[e].br;
            mark();
            cyc();
            chk("cfg_cleared", {clk_bitstream, clk_symbol, clk_filter_sample}, 0);
            while (rise1[1] < 0 && edge_n < 20000) cyc();
            chk("tbl_bit_rise", rise1[0], tbl[e].bit_rise);
            chk("tbl_bit_fall", fall1[0], tbl[e].bit_fall);
            chk("tbl_sym_rise", rise1[1], tbl[e].sym_rise);
            chk("tbl_filt_rise", rise1[2], tbl[e].filt_rise);
            chk("tbl_filt_rise2", rise2[2], tbl[e].filt_rise2);
        end

        // 50 kHz carrier from reset
        #1 rst_n = 1'b0;
        carrier_freq_set = 16'd50000;
        repeat (2) cyc();
        #1 rst_n = 1'b1;
        prevq  = 0;
        last_x = 0;
        n_sp   = 0;
        for (int m = 1; m <= 60; m++) begin
            repeat (16) cyc();
            ci_r = real'(longint'(carrier_i));
            cq_r = real'(longint'(carrier_q));
            err  = ci_r * ci_r + cq_r * cq_r - real'(AMP) * real'(AMP);
            if (err < 0.0) err = -err;
            chk_ok("carrier_norm", err < 1.0e-6 * real'(AMP) * real'(AMP),
                   longint'(carrier_i), longint'(carrier_q));
            if (m == 5) begin
                chk_ok("s4_sin", cq_r > 0.968 * real'(AMP) && cq_r < 0.972 * real'(AMP),
                       longint'(carrier_q), 1041529000);
                chk_ok("s4_cos", ci_r < -0.241 * real'(AMP) && ci_r > -0.245 * real'(AMP),
                       longint'(carrier_i), -260906000);
            end
            if (m > 1 && prevq < 0 && longint'(carrier_q) >= 0) begin
                if (last_x > 0) begin
                    chk_ok("carrier_period", (m - last_x) == 13 || (m - last_x) == 14,
                           m - last_x, 14);
                    n_sp++;
                end
                last_x = m;
            end
            prevq = longint'(carrier_q);
        end
        chk_ok("period_seen", n_sp >= 2, n_sp, 2);

        // Randomized run against the model
        for (int c = 0; c < 6000; c++) begin
            cyc();
            baseband_i = 68'({$urandom, $urandom, $urandom});
            baseband_q = 68'({$urandom, $urandom, $urandom});
            if ($urandom_range(0, 49) == 0)
                carrier_freq_set = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 2999) == 0) begin
                mod_type  = ~mod_type;
                baud_rate = 2'($urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
